clock_gate_ctrl: RTL and testbench

- Per-domain clock-gating controller for the baseband core.
- Sequences the `en` inputs of N gated-clock cells (one per domain, e.g. correlator, FFT, accumulator).
- Turns a domain's clock on when it has work, holds off the domain's acknowledge until the gated clock is stable, and gates the clock off after a programmable idle period.
- Sits between requester logic and the gated-clock cells. The cells' test input is driven separately and is not handled here.

---
 rtl/clock_gate_pkg.sv | 18 +
 rtl/clock_gate_chan.sv | 110 +++++++++++
 rtl/clock_gate_ctrl.sv | 57 +++++
 tb/tb_clock_gate_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_gate_pkg.sv
// Shared definitions for the clock-gating controller: per-channel state
// encoding and default parameter values.
package clock_gate_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_IDLE = 2'd3
    } chan_state_e;

    localparam int DEF_CH_NUM      = 4;
    localparam int DEF_IDLE_CYCLES = 16;
    localparam int DEF_IDLE_W      = 5;
    localparam int DEF_WAKE_CYCLES = 2;
    localparam int ON_CNT_W        = 16;

endpackage

// File: rtl/clock_gate_chan.sv
// Single-domain clock-gate sequencer: OFF/WAKE/ON/IDLE FSM with wake and
// idle counters. Optional clock-on cycle counter under CLK_GATE_STAT_EN.
module clock_gate_chan
    import clock_gate_pkg::*;
#(
    parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
    parameter int IDLE_W      = DEF_IDLE_W,
    parameter int WAKE_CYCLES = DEF_WAKE_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic                i_auto_en,
    input  logic                i_force_off,
`ifdef CLK_GATE_STAT_EN
    input  logic                i_stat_clr,
    output logic [ON_CNT_W-1:0] o_on_cnt,
`endif
    output logic                o_clk_en,
    output logic                o_ack,
    output logic                o_nxt_off
);

    localparam logic [1:0]        WAKE_LAST = 2'(WAKE_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);

    chan_state_e       r_state, w_state_nxt;
    logic [1:0]        r_wake_cnt, w_wake_nxt;
    logic [IDLE_W-1:0] r_idle_cnt, w_idle_nxt;
    logic              w_wake_cond;

    assign w_wake_cond = !i_force_off && (i_req || !i_auto_en);

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_OFF;
            r_wake_cnt <= '0;
            r_idle_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wake_cnt <= w_wake_nxt;
            r_idle_cnt <= w_idle_nxt;
        end
    end

    // Next-state and counter update; force_off outranks every other event
    always_comb begin
        w_state_nxt = r_state;
        w_wake_nxt  = r_wake_cnt;
        w_idle_nxt  = r_idle_cnt;
        case (r_state)
            ST_OFF: begin
                if (w_wake_cond) begin
                    w_state_nxt = ST_WAKE;
                    w_wake_nxt  = '0;
                end
            end
            ST_WAKE: begin
                // req dropping here does not abort the wake-up
                if (i_force_off)                 w_state_nxt = ST_OFF;
                else if (r_wake_cnt == WAKE_LAST) w_state_nxt = ST_ON;
                else                              w_wake_nxt  = r_wake_cnt + 2'd1;
            end
            ST_ON: begin
                if (i_force_off) begin
                    w_state_nxt = ST_OFF;
                end else if (i_auto_en && !i_req) begin
                    w_state_nxt = ST_IDLE;
                    w_idle_nxt  = '0;
                end
            end
            ST_IDLE: begin
                // new work beats expiry on the same cycle
                if (i_force_off) begin
                    w_state_nxt = ST_OFF;
                end else if (i_req || !i_auto_en) begin
                    w_state_nxt = ST_ON;
                    w_idle_nxt  = '0;
                end else if (r_idle_cnt == IDLE_LAST) begin
                    w_state_nxt = ST_OFF;
                end else begin
                    w_idle_nxt  = r_idle_cnt + IDLE_W'(1);
                end
            end
            default: w_state_nxt = ST_OFF;
        endcase
    end

    assign o_clk_en  = (r_state != ST_OFF);
    assign o_ack     = (r_state == ST_ON) || (r_state == ST_IDLE);
    assign o_nxt_off = (w_state_nxt == ST_OFF);

`ifdef CLK_GATE_STAT_EN
    logic [ON_CNT_W-1:0] r_on_cnt;

    // Saturating count of cycles with the domain clock running
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_on_cnt <= '0;
        else if (i_stat_clr)
            r_on_cnt <= '0;
        else if (o_clk_en && (r_on_cnt != {ON_CNT_W{1'b1}}))
            r_on_cnt <= r_on_cnt + ON_CNT_W'(1);
    end

    assign o_on_cnt = r_on_cnt;
`endif

endmodule

// File: rtl/clock_gate_ctrl.sv
// Per-domain clock-gating controller: one clock_gate_chan per domain plus a
// registered all-off flag. Define CLK_GATE_STAT_EN for clock-on statistics.
module clock_gate_ctrl
    import clock_gate_pkg::*;
#(
    parameter int CH_NUM      = DEF_CH_NUM,
    parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
    parameter int IDLE_W      = DEF_IDLE_W,
    parameter int WAKE_CYCLES = DEF_WAKE_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CH_NUM-1:0]          req,
    input  logic [CH_NUM-1:0]          auto_en,
    input  logic [CH_NUM-1:0]          force_off,
`ifdef CLK_GATE_STAT_EN
    input  logic                       stat_clr,
    output logic [CH_NUM*ON_CNT_W-1:0] on_cnt,
`endif
    output logic [CH_NUM-1:0]          clk_en,
    output logic [CH_NUM-1:0]          ack,
    output logic                       all_off
);

    logic [CH_NUM-1:0] w_nxt_off;
    logic              r_all_off;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_chan
        clock_gate_chan #(
            .IDLE_CYCLES (IDLE_CYCLES),
            .IDLE_W      (IDLE_W),
            .WAKE_CYCLES (WAKE_CYCLES)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .i_req       (req[g]),
            .i_auto_en   (auto_en[g]),
            .i_force_off (force_off[g]),
`ifdef CLK_GATE_STAT_EN
            .i_stat_clr  (stat_clr),
            .o_on_cnt    (on_cnt[g*ON_CNT_W +: ON_CNT_W]),
`endif
            .o_clk_en    (clk_en[g]),
            .o_ack       (ack[g]),
            .o_nxt_off   (w_nxt_off[g])
        );
    end

    // all_off registered from next states so it moves with the state flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_all_off <= 1'b1;
        else     r_all_off <= &w_nxt_off;
    end

    assign all_off = r_all_off;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Scoreboard bench for clock_gate_ctrl: a cycle model pushes expected outputs
// at each rising edge, a monitor pops and compares on the falling edge.
module tb_clock_gate_ctrl;

    localparam int CH = 4;
    localparam int IC = 16;
    localparam int IW = 5;
    localparam int WC = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] req = '0;
    logic [CH-1:0] auto_en = '1;
    logic [CH-1:0] force_off = '0;
    logic [CH-1:0] clk_en, ack;
    logic          all_off;
`ifdef CLK_GATE_STAT_EN
    logic             stat_clr = 1'b0;
    logic [CH*16-1:0] on_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [CH-1:0] en;
        logic [CH-1:0] ack;
        logic          all_off;
    } obs_t;

    obs_t exp_q[$];

    // model: is the clock running, cycles since it started, consecutive idle samples
    bit m_run[CH];
    int m_warm[CH];
    int m_quiet[CH];

    always #5 clk = ~clk;

    clock_gate_ctrl #(
        .CH_NUM(CH), .IDLE_CYCLES(IC), .IDLE_W(IW), .WAKE_CYCLES(WC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .auto_en   (auto_en),
        .force_off (force_off),
`ifdef CLK_GATE_STAT_EN
        .stat_clr  (stat_clr),
        .on_cnt    (on_cnt),
`endif
        .clk_en    (clk_en),
        .ack       (ack),
        .all_off   (all_off)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of the behavioural model, using the inputs sampled at this edge
    task automatic model_step();
        obs_t o;
        o.all_off = 1'b1;
        for (int c = 0; c < CH; c++) begin
            if (rst) begin
                m_run[c] = 0; m_warm[c] = 0; m_quiet[c] = 0;
            end else if (!m_run[c]) begin
                if (!force_off[c] && (req[c] || !auto_en[c])) begin
                    m_run[c] = 1; m_warm[c] = 0; m_quiet[c] = 0;
                end
            end else if (force_off[c]) begin
                m_run[c] = 0;
            end else if (m_warm[c] < WC) begin
                m_warm[c]++;
            end else if (auto_en[c] && !req[c]) begin
                m_quiet[c]++;
                if (m_quiet[c] == IC + 1) m_run[c] = 0;
            end else begin
                m_quiet[c] = 0;
            end
            o.en[c]  = m_run[c];
            o.ack[c] = m_run[c] && (m_warm[c] >= WC);
            if (m_run[c]) o.all_off = 1'b0;
        end
        exp_q.push_back(o);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // monitor
    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_outputs", {23'd0, clk_en, ack, all_off}, {23'd0, e});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Edges until clk_en[ch] and ack[ch] first take value val
    task automatic measure(input string name, input int ch, input bit val,
                           input int exp_en, input int exp_ack);
        int k_en = 999, k_ack = 999;
        for (int i = 1; i <= 40 && (k_en == 999 || k_ack == 999); i++) begin
            @(posedge clk); #1;
            if (k_en  == 999 && clk_en[ch] == val) k_en  = i;
            if (k_ack == 999 && ack[ch]    == val) k_ack = i;
        end
        check({name, "_clk_en_edges"}, k_en, exp_en);
        check({name, "_ack_edges"}, k_ack, exp_ack);
    endtask

    initial begin
        tick(3);
        check("rst_clk_en", clk_en, 0);
        check("rst_ack", ack, 0);
        check("rst_all_off", all_off, 1);
`ifdef CLK_GATE_STAT_EN
        check("rst_on_cnt", on_cnt, 0);
`endif
        rst = 1'b0;

        // quiet period, nothing wakes
        tick(50);
        check("quiet_all_off", all_off, 1);

        // wake-up latency on channel 0
        req[0] = 1'b1;
        measure("wake", 0, 1'b1, 1, 1 + WC);
        check("wake_all_off", all_off, 0);

        // automatic gate-off latency
        tick(10);
        req[0] = 1'b0;
        measure("gate_off", 0, 1'b0, 1 + IC, 1 + IC);

        // request pulse landing exactly on the expiry sample keeps the clock
        req[0] = 1'b1; tick(5);
        req[0] = 1'b0; tick(IC);
        req[0] = 1'b1; tick(1);
        req[0] = 1'b0;
        check("expiry_req_on", clk_en[0], 1);
        tick(IC);
        check("expiry_restart_on", clk_en[0], 1);
        tick(5);
        check("expiry_restart_off", clk_en[0], 0);

        // auto_en low keeps channel 1 clocked; force_off then powers it down
        auto_en[1] = 1'b0; tick(40);
        check("manual_ack", ack[1], 1);
        force_off[1] = 1'b1; tick(1);
        check("force_on_off", clk_en[1], 0);
        force_off[1] = 1'b0; tick(1);
        check("rewake_clk_en", {clk_en[1], ack[1]}, 2'b10);
        force_off[1] = 1'b1; tick(1);
        check("force_wake_off", {clk_en[1], ack[1]}, 2'b00);
        auto_en[1] = 1'b1; force_off[1] = 1'b0; tick(3);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 15) == 0) req[c]       = ~req[c];
                if ($urandom_range(0, 59) == 0) auto_en[c]   = ~auto_en[c];
                if ($urandom_range(0, 39) == 0) force_off[c] = ~force_off[c];
            end
            tick(1);
        end

        // asynchronous reset with every channel in IDLE
        auto_en = '1; force_off = '0; req = '1; tick(10);
        req = '0; tick(5);
        check("pre_rst_ack", ack, 4'hF);
        @(negedge clk); #1;
        rst = 1'b1; #1;
        check("async_rst_clk_en", clk_en, 0);
        check("async_rst_ack", ack, 0);
        check("async_rst_all_off", all_off, 1);
        tick(2);
        rst = 1'b0;

`ifdef CLK_GATE_STAT_EN
        check("stat_after_rst", on_cnt, 0);
        req[0] = 1'b1; tick(101);
        check("stat_cnt_100", on_cnt[15:0], 100);
        stat_clr = 1'b1; tick(1);
        check("stat_clr", on_cnt[15:0], 0);
        stat_clr = 1'b0;
        req[0] = 1'b0;
`endif
        tick(3);
        @(negedge clk); #1;
        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
